// File: rtl/vga_rx_monitor.sv
// rtl/vga_rx_monitor.sv - VGA receive-side timing, checksum and probe monitor
// Optional frame statistics counters are built when VGA_MON_STATS_EN is defined.
module vga_rx_monitor #(
  parameter int   H_TOTAL  = 800,
  parameter int   H_ACTIVE = 640,
  parameter int   V_TOTAL  = 525,
  parameter int   V_ACTIVE = 480,
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b0
) (
  input  logic        CLOCK_50,
  input  logic        SW,
  input  logic        VGA_CLK,
  input  logic        VGA_HS,
  input  logic        VGA_VS,
  input  logic        VGA_BLANK_N,
  input  logic [7:0]  VGA_R,
  input  logic [7:0]  VGA_G,
  input  logic [7:0]  VGA_B,
  input  logic [9:0]  PROBE_X,
  input  logic [9:0]  PROBE_Y,
  output logic        locked,
  output logic        frame_done,
  output logic [11:0] h_total_meas,
  output logic [11:0] v_total_meas,
  output logic        err_htotal,
  output logic        err_hactive,
  output logic        err_vtotal,
  output logic        err_vactive,
  output logic [23:0] frame_sum,
  output logic [23:0] probe_rgb,
  output logic [15:0] frame_cnt,
  output logic [15:0] err_frame_cnt
);

  localparam logic [1:0]  ST_SEARCH  = 2'd0;
  localparam logic [1:0]  ST_MEASURE = 2'd1;
  localparam logic [1:0]  ST_LOCKED  = 2'd2;
  localparam logic [11:0] CNT_MAX    = 12'hFFF;
  localparam logic [11:0] H_TOTAL_W  = 12'(H_TOTAL);
  localparam logic [11:0] H_ACTIVE_W = 12'(H_ACTIVE);
  localparam logic [11:0] V_TOTAL_W  = 12'(V_TOTAL);
  localparam logic [11:0] V_ACTIVE_W = 12'(V_ACTIVE);

  function automatic logic [11:0] sat_inc(input logic [11:0] v);
    return (v == CNT_MAX) ? v : v + 12'd1;
  endfunction

  // Input stage is a plain pipeline; leaving it out of reset avoids a false strobe on release.
  logic        s1_clk, s2_clk, s1_hs, s1_vs, s1_blank_n;
  logic [23:0] s1_rgb;

  always_ff @(posedge CLOCK_50) begin
    s1_clk     <= VGA_CLK;
    s2_clk     <= s1_clk;
    s1_hs      <= VGA_HS;
    s1_vs      <= VGA_VS;
    s1_blank_n <= VGA_BLANK_N;
    s1_rgb     <= {VGA_R, VGA_G, VGA_B};
  end

  logic [1:0]  state;
  logic        hs_a_prev, vs_a_prev, frame_err;
  logic [11:0] hcnt, acnt, lcnt, aline;
  logic [23:0] sum, shadow;

  logic        pstb, hs_a, vs_a, hs_edge, vs_edge, checking;
  logic        h_bad, a_bad, v_bad, va_bad, line_err, frame_bad, probe_hit;
  logic [11:0] lcnt_eff, aline_eff;

  assign pstb     = s1_clk & ~s2_clk;
  assign hs_a     = (s1_hs == HS_POL);
  assign vs_a     = (s1_vs == VS_POL);
  assign hs_edge  = pstb & hs_a & ~hs_a_prev;
  assign vs_edge  = pstb & vs_a & ~vs_a_prev;
  assign checking = (state != ST_SEARCH);
  assign locked   = (state == ST_LOCKED);

  // Line-end is applied before frame-end, so frame checks see the final line counted.
  assign lcnt_eff  = hs_edge ? sat_inc(lcnt) : lcnt;
  assign aline_eff = (hs_edge && acnt != 12'd0) ? sat_inc(aline) : aline;

  assign h_bad     = (hcnt != H_TOTAL_W) | (hcnt == CNT_MAX);
  assign a_bad     = (acnt != 12'd0) & ((acnt != H_ACTIVE_W) | (acnt == CNT_MAX));
  assign v_bad     = (lcnt_eff != V_TOTAL_W) | (lcnt_eff == CNT_MAX);
  assign va_bad    = (aline_eff != V_ACTIVE_W) | (aline_eff == CNT_MAX);
  assign line_err  = hs_edge & (h_bad | a_bad);
  assign frame_bad = frame_err | line_err | v_bad | va_bad;
  assign probe_hit = s1_blank_n & (acnt == {2'b00, PROBE_X}) & (aline == {2'b00, PROBE_Y});

  always_ff @(posedge CLOCK_50) begin
    if (SW) begin
      state        <= ST_SEARCH;
      hs_a_prev    <= 1'b0;
      vs_a_prev    <= 1'b0;
      frame_err    <= 1'b0;
      hcnt         <= 12'd0;
      acnt         <= 12'd0;
      lcnt         <= 12'd0;
      aline        <= 12'd0;
      sum          <= 24'd0;
      shadow       <= 24'd0;
      frame_done   <= 1'b0;
      h_total_meas <= 12'd0;
      v_total_meas <= 12'd0;
      err_htotal   <= 1'b0;
      err_hactive  <= 1'b0;
      err_vtotal   <= 1'b0;
      err_vactive  <= 1'b0;
      frame_sum    <= 24'd0;
      probe_rgb    <= 24'd0;
    end else begin
      frame_done <= 1'b0;
      if (pstb) begin
        hs_a_prev <= hs_a;
        vs_a_prev <= vs_a;
        if (s1_blank_n) sum <= sum + s1_rgb;
        if (probe_hit) shadow <= s1_rgb;
        if (hs_edge) begin
          h_total_meas <= hcnt;
          hcnt         <= 12'd1;
          acnt         <= 12'd0;
          lcnt         <= lcnt_eff;
          aline        <= aline_eff;
          if (checking && h_bad) err_htotal  <= 1'b1;
          if (checking && a_bad) err_hactive <= 1'b1;
          if (checking && line_err) frame_err <= 1'b1;
        end else begin
          hcnt <= sat_inc(hcnt);
          if (s1_blank_n) acnt <= sat_inc(acnt);
        end
        if (vs_edge) begin
          v_total_meas <= lcnt_eff;
          frame_sum    <= sum;
          probe_rgb    <= shadow;
          sum          <= s1_blank_n ? s1_rgb : 24'd0;
          lcnt         <= 12'd0;
          aline        <= 12'd0;
          frame_err    <= 1'b0;
          if (checking && v_bad)  err_vtotal  <= 1'b1;
          if (checking && va_bad) err_vactive <= 1'b1;
          case (state)
            ST_SEARCH: state <= ST_MEASURE;
            ST_MEASURE: begin
              frame_done <= 1'b1;
              if (!frame_bad) state <= ST_LOCKED;
            end
            ST_LOCKED: begin
              frame_done <= 1'b1;
              if (frame_bad) state <= ST_MEASURE;
            end
            default: state <= ST_SEARCH;
          endcase
        end
      end
    end
  end

`ifdef VGA_MON_STATS_EN
  always_ff @(posedge CLOCK_50) begin
    if (SW) begin
      frame_cnt     <= 16'd0;
      err_frame_cnt <= 16'd0;
    end else if (vs_edge && checking) begin
      frame_cnt <= frame_cnt + 16'd1;
      if (frame_bad) err_frame_cnt <= err_frame_cnt + 16'd1;
    end
  end
`else
  assign frame_cnt     = 16'd0;
  assign err_frame_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_vga_rx_monitor.sv
// tb/tb_vga_rx_monitor.sv - directed self-checking bench for vga_rx_monitor
module tb_vga_rx_monitor;

  localparam int HT = 20;
  localparam int HA = 12;
  localparam int VT = 10;
  localparam int VA = 6;

  logic        CLOCK_50 = 1'b0;
  logic        SW = 1'b1;
  logic        VGA_CLK = 1'b1;
  logic        VGA_HS = 1'b1;
  logic        VGA_VS = 1'b1;
  logic        VGA_BLANK_N = 1'b0;
  logic [7:0]  VGA_R = 8'd0;
  logic [7:0]  VGA_G = 8'd0;
  logic [7:0]  VGA_B = 8'd0;
  logic [9:0]  PROBE_X = 10'd3;
  logic [9:0]  PROBE_Y = 10'd2;
  logic        locked, frame_done;
  logic [11:0] h_total_meas, v_total_meas;
  logic        err_htotal, err_hactive, err_vtotal, err_vactive;
  logic [23:0] frame_sum, probe_rgb;
  logic [15:0] frame_cnt, err_frame_cnt;

  int   checks = 0;
  int   passed = 0;
  int   fd_total = 0;
  int   drop_seen = 0;
  logic drop_fd = 1'b0;
  logic prev_locked = 1'b0;

  vga_rx_monitor #(
    .H_TOTAL(HT), .H_ACTIVE(HA), .V_TOTAL(VT), .V_ACTIVE(VA), .HS_POL(1'b0), .VS_POL(1'b0)
  ) dut (
    .CLOCK_50(CLOCK_50), .SW(SW), .VGA_CLK(VGA_CLK), .VGA_HS(VGA_HS), .VGA_VS(VGA_VS),
    .VGA_BLANK_N(VGA_BLANK_N), .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
    .PROBE_X(PROBE_X), .PROBE_Y(PROBE_Y), .locked(locked), .frame_done(frame_done),
    .h_total_meas(h_total_meas), .v_total_meas(v_total_meas), .err_htotal(err_htotal),
    .err_hactive(err_hactive), .err_vtotal(err_vtotal), .err_vactive(err_vactive),
    .frame_sum(frame_sum), .probe_rgb(probe_rgb), .frame_cnt(frame_cnt),
    .err_frame_cnt(err_frame_cnt)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  always @(negedge CLOCK_50) begin
    if (frame_done === 1'b1) fd_total++;
    if (prev_locked === 1'b1 && locked === 1'b0) begin
      drop_seen++;
      drop_fd = frame_done;
    end
    prev_locked = locked;
  end

  // One pixel = one VGA_CLK period = two CLOCK_50 cycles; data changes while VGA_CLK is low.
  task automatic pixel(input logic hs, input logic vs, input logic bn, input logic [23:0] rgb);
    @(posedge CLOCK_50); #1;
    VGA_CLK = 1'b0;
    VGA_HS = hs;
    VGA_VS = vs;
    VGA_BLANK_N = bn;
    {VGA_R, VGA_G, VGA_B} = rgb;
    @(posedge CLOCK_50); #1;
    VGA_CLK = 1'b1;
  endtask

  // Sync at x<2 / y<2, active x 2..13 and y 2..7; long_y gets one extra blank pixel.
  task automatic send_lines(input int y0, input int y1, input int long_y,
                            input logic [23:0] base, input logic [23:0] pcol);
    int len;
    logic act;
    logic [23:0] c;
    for (int y = y0; y <= y1; y++) begin
      len = (y == long_y) ? HT + 1 : HT;
      for (int x = 0; x < len; x++) begin
        act = (x >= 2 && x < 2 + HA && y >= 2 && y < 2 + VA);
        c = (x - 2 == int'(PROBE_X) && y - 2 == int'(PROBE_Y)) ? pcol : base;
        pixel((x < 2) ? 1'b0 : 1'b1, (y < 2) ? 1'b0 : 1'b1, act, act ? c : 24'h0);
      end
    end
  endtask

  task automatic send_frame(input int long_y, input logic [23:0] base, input logic [23:0] pcol);
    send_lines(0, VT - 1, long_y, base, pcol);
  endtask

  task automatic test_reset;
    SW = 1'b1;
    repeat (3) @(posedge CLOCK_50);
    #1;
    SW = 1'b0;
    checks++; if (locked !== 1'b0) $display("FAIL reset_locked: got %b want 0", locked); else passed++;
    checks++; if (frame_done !== 1'b0) $display("FAIL reset_frame_done: got %b want 0", frame_done); else passed++;
    checks++; if (h_total_meas !== 12'd0) $display("FAIL reset_htotal: got %0d want 0", h_total_meas); else passed++;
    checks++; if (v_total_meas !== 12'd0) $display("FAIL reset_vtotal: got %0d want 0", v_total_meas); else passed++;
    checks++; if ({err_htotal, err_hactive, err_vtotal, err_vactive} !== 4'b0)
      $display("FAIL reset_errs: got %b want 0000", {err_htotal, err_hactive, err_vtotal, err_vactive}); else passed++;
    checks++; if (frame_sum !== 24'd0) $display("FAIL reset_sum: got %h want 000000", frame_sum); else passed++;
    checks++; if (probe_rgb !== 24'd0) $display("FAIL reset_probe: got %h want 000000", probe_rgb); else passed++;
    checks++; if ({frame_cnt, err_frame_cnt} !== 32'd0)
      $display("FAIL reset_stats: got %0d/%0d want 0/0", frame_cnt, err_frame_cnt); else passed++;
  endtask

  task automatic test_ideal;
    int fd0;
    fd0 = fd_total;
    repeat (3) send_frame(-1, 24'h000001, 24'h000001);
    checks++; if (fd_total - fd0 != 2) $display("FAIL ideal_fd_count: got %0d want 2", fd_total - fd0); else passed++;
    checks++; if (locked !== 1'b1) $display("FAIL ideal_locked: got %b want 1", locked); else passed++;
    checks++; if (h_total_meas !== 12'd20) $display("FAIL ideal_htotal: got %0d want 20", h_total_meas); else passed++;
    checks++; if (v_total_meas !== 12'd10) $display("FAIL ideal_vtotal: got %0d want 10", v_total_meas); else passed++;
    checks++; if ({err_htotal, err_hactive, err_vtotal, err_vactive} !== 4'b0)
      $display("FAIL ideal_errs: got %b want 0000", {err_htotal, err_hactive, err_vtotal, err_vactive}); else passed++;
    checks++; if (frame_sum !== 24'h000048) $display("FAIL ideal_sum: got %h want 000048", frame_sum); else passed++;
    checks++; if (probe_rgb !== 24'h000001) $display("FAIL ideal_probe: got %h want 000001", probe_rgb); else passed++;
  endtask

  task automatic test_probe;
    send_frame(-1, 24'h000001, 24'hABCDEF);
    send_frame(-1, 24'h000001, 24'h000001);
    checks++; if (probe_rgb !== 24'hABCDEF) $display("FAIL probe_rgb: got %h want abcdef", probe_rgb); else passed++;
    checks++; if (frame_sum !== 24'hABCE36) $display("FAIL probe_sum: got %h want abce36", frame_sum); else passed++;
    checks++; if (locked !== 1'b1) $display("FAIL probe_locked: got %b want 1", locked); else passed++;
  endtask

  task automatic test_htotal_err;
    int d0;
    d0 = drop_seen;
    send_frame(4, 24'h000001, 24'h000001);
    checks++; if (err_htotal !== 1'b1) $display("FAIL herr_flag: got %b want 1", err_htotal); else passed++;
    checks++; if (locked !== 1'b1) $display("FAIL herr_midframe_locked: got %b want 1", locked); else passed++;
    send_frame(-1, 24'h000001, 24'h000001);
    checks++; if (locked !== 1'b0) $display("FAIL herr_unlock: got %b want 0", locked); else passed++;
    checks++; if (drop_seen - d0 != 1 || drop_fd !== 1'b1)
      $display("FAIL herr_unlock_timing: got drops=%0d fd=%b want drops=1 fd=1", drop_seen - d0, drop_fd); else passed++;
    send_frame(-1, 24'h000001, 24'h000001);
    checks++; if (locked !== 1'b1) $display("FAIL herr_relock: got %b want 1", locked); else passed++;
    checks++; if (err_htotal !== 1'b1) $display("FAIL herr_sticky: got %b want 1", err_htotal); else passed++;
    checks++; if (err_vtotal !== 1'b0) $display("FAIL herr_vtotal_clean: got %b want 0", err_vtotal); else passed++;
  endtask

  task automatic test_reset_midframe;
    int fd0;
    send_lines(0, 5, -1, 24'h000001, 24'h000001);
    SW = 1'b1;
    @(posedge CLOCK_50); #1;
    SW = 1'b0;
    checks++; if (locked !== 1'b0) $display("FAIL mid_reset_locked: got %b want 0", locked); else passed++;
    checks++; if (err_htotal !== 1'b0) $display("FAIL mid_reset_err: got %b want 0", err_htotal); else passed++;
    checks++; if (frame_sum !== 24'd0) $display("FAIL mid_reset_sum: got %h want 000000", frame_sum); else passed++;
    checks++; if (probe_rgb !== 24'd0) $display("FAIL mid_reset_probe: got %h want 000000", probe_rgb); else passed++;
    checks++; if ({h_total_meas, v_total_meas} !== 24'd0)
      $display("FAIL mid_reset_meas: got %0d/%0d want 0/0", h_total_meas, v_total_meas); else passed++;
    fd0 = fd_total;
    send_lines(6, VT - 1, -1, 24'h000001, 24'h000001);
    send_frame(-1, 24'h000001, 24'h000001);
    checks++; if (fd_total - fd0 != 0) $display("FAIL mid_reset_early_fd: got %0d want 0", fd_total - fd0); else passed++;
    send_frame(-1, 24'h000001, 24'h000001);
    checks++; if (fd_total - fd0 != 1) $display("FAIL mid_reset_first_fd: got %0d want 1", fd_total - fd0); else passed++;
    checks++; if (locked !== 1'b1) $display("FAIL mid_reset_relock: got %b want 1", locked); else passed++;
    checks++; if (frame_sum !== 24'h000048) $display("FAIL mid_reset_sum_after: got %h want 000048", frame_sum); else passed++;
  endtask

  task automatic test_stats;
    logic [15:0] exp_fc, exp_ec;
`ifdef VGA_MON_STATS_EN
    exp_fc = 16'd3;
    exp_ec = 16'd1;
`else
    exp_fc = 16'd0;
    exp_ec = 16'd0;
`endif
    SW = 1'b1;
    repeat (2) @(posedge CLOCK_50);
    #1;
    SW = 1'b0;
    send_frame(-1, 24'h000001, 24'h000001);
    send_frame(-1, 24'h000001, 24'h000001);
    send_frame(3, 24'h000001, 24'h000001);
    send_frame(-1, 24'h000001, 24'h000001);
    checks++; if (frame_cnt !== exp_fc) $display("FAIL stats_frame_cnt: got %0d want %0d", frame_cnt, exp_fc); else passed++;
    checks++; if (err_frame_cnt !== exp_ec) $display("FAIL stats_err_frame_cnt: got %0d want %0d", err_frame_cnt, exp_ec); else passed++;
    checks++; if (locked !== 1'b0) $display("FAIL stats_unlocked: got %b want 0", locked); else passed++;
  endtask

  initial begin
    test_reset;
    test_ideal;
    test_probe;
    test_htotal_err;
    test_reset_midframe;
    test_stats;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
